// File: rtl/adder_pkg.sv
// adder_pkg: FSM state encoding and add/subtract mode constants for serial_skip_adder.
package adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_skip_adder_if.sv
// serial_skip_adder_if: operation request and result bundle for serial_skip_adder.
interface serial_skip_adder_if #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
);
   localparam int NBLK = WIDTH / BLK;
   localparam int CW   = $clog2(NBLK + 1);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic [CW-1:0]    skip_cnt;
   modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out, ovf, skip_cnt);
   modport slave  (input start, sub, a, b, c_in, output busy, done, sum, c_out, ovf, skip_cnt);
endinterface

// File: rtl/skip_block.sv
// skip_block: combinational BLK-bit ripple adder with block propagate and carry into the top bit.
module skip_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a_i,
   input  logic [BLK-1:0] b_i,
   input  logic           c_i,
   output logic [BLK-1:0] s_o,
   output logic           p_o,
   output logic           c_o,
   output logic           cm_o
);
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{BLK{1'b0}}, c_i};
   assign p_o        = &(a_i ^ b_i);
   // carry into the top bit recovered from its sum bit
   assign cm_o       = s_o[BLK-1] ^ a_i[BLK-1] ^ b_i[BLK-1];
endmodule

// File: rtl/serial_skip_adder.sv
// serial_skip_adder: multi-cycle add/subtract processing one BLK-bit carry-skip block per cycle, LSB first.
module serial_skip_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
) (
   input  logic               clk,
   input  logic               rst,
   serial_skip_adder_if.slave bus
);
   localparam int NBLK = WIDTH / BLK;
   localparam int CW   = $clog2(NBLK + 1);
   localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;

   if (BLK <= 0 || WIDTH <= 0 || (WIDTH % BLK) != 0) begin : g_bad_width
      $error("serial_skip_adder: WIDTH must be a positive multiple of BLK");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    skip_q, skip_d;
   logic [BLK-1:0]   blk_s;
   logic             blk_p, blk_co, blk_cm, blk_cout, last;

   skip_block #(.BLK(BLK)) u_blk (
      .a_i  (a_q[idx_q*BLK +: BLK]),
      .b_i  (b_q[idx_q*BLK +: BLK]),
      .c_i  (carry_q),
      .s_o  (blk_s),
      .p_o  (blk_p),
      .c_o  (blk_co),
      .cm_o (blk_cm)
   );

   // a fully propagating block passes its carry-in straight through
   assign blk_cout = blk_p ? carry_q : blk_co;
   assign last     = idx_q == IW'(NBLK - 1);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      skip_d  = skip_q;
      if (state_q == IDLE && bus.start) begin
         state_d = RUN;
         a_d     = bus.a;
         b_d     = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
         carry_d = (bus.sub == MODE_SUB) ? ~bus.c_in : bus.c_in;
         idx_d   = '0;
         skip_d  = '0;
      end else if (state_q == RUN) begin
         sum_d[idx_q*BLK +: BLK] = blk_s;
         carry_d = blk_cout;
         skip_d  = skip_q + CW'(blk_p);
         idx_d   = idx_q + 1'b1;
         state_d = last ? DONE : RUN;
         c_out_d = last ? blk_cout : c_out_q;
         ovf_d   = last ? (blk_cm ^ blk_cout) : ovf_q;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
         skip_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
         skip_q  <= skip_d;
      end
   end

   assign bus.busy     = state_q != IDLE;
   assign bus.done     = state_q == DONE;
   assign bus.sum      = sum_q;
   assign bus.c_out    = c_out_q;
   assign bus.ovf      = ovf_q;
   assign bus.skip_cnt = skip_q;
endmodule

// File: tb/tb_serial_skip_adder.sv
// tb_serial_skip_adder: scoreboard bench for serial_skip_adder with an arithmetic reference model.
module tb_serial_skip_adder;
   localparam int WIDTH = 16;
   localparam int BLK   = 4;
   localparam int NBLK  = WIDTH / BLK;
   localparam int CW    = $clog2(NBLK + 1);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             c_out;
      logic             ovf;
      logic [CW-1:0]    skip;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   serial_skip_adder_if #(.WIDTH(WIDTH), .BLK(BLK)) bus ();
   serial_skip_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub);
      logic [WIDTH:0]   r;
      logic [WIDTH-1:0] be;
      logic [BLK-1:0]   x;
      exp_t             e;
      if (sub) begin
         r       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
         e.c_out = ~r[WIDTH];
         e.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end else begin
         r       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         e.c_out = r[WIDTH];
         e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      e.sum  = r[WIDTH-1:0];
      be     = sub ? ~b : b;
      e.skip = '0;
      for (int k = 0; k < NBLK; k++) begin
         x = a[k*BLK +: BLK] ^ be[k*BLK +: BLK];
         if (&x) e.skip = e.skip + 1'b1;
      end
      return e;
   endfunction

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input string tag);
      exp_t e;
      exp_t got;
      int   n;
      @(negedge clk);
      bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub; bus.start = 1'b1;
      sb.push_back(model(a, b, cin, sub));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.c_in = ~cin; bus.sub = ~sub;
      n = 1;
      while (!bus.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.done) begin
         errors++;
         $display("FAIL %s timeout: done=%b after %0d cycles, required 1", tag, bus.done, n);
         void'(sb.pop_front());
         return;
      end
      checks++;
      if (n !== NBLK + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", tag, n, NBLK + 1);
      end
      e   = sb.pop_front();
      got = {bus.sum, bus.c_out, bus.ovf, bus.skip_cnt};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s result: got sum=%h c_out=%b ovf=%b skip=%0d required sum=%h c_out=%b ovf=%b skip=%0d",
                  tag, got.sum, got.c_out, got.ovf, got.skip, e.sum, e.c_out, e.ovf, e.skip);
      end
      @(negedge clk);
      @(negedge clk);
      got = {bus.sum, bus.c_out, bus.ovf, bus.skip_cnt};
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || got !== e) begin
         errors++;
         $display("FAIL %s hold: got done=%b busy=%b sum=%h required done=0 busy=0 sum=%h",
                  tag, bus.done, bus.busy, got.sum, e.sum);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.skip_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b sum=%h c_out=%b ovf=%b skip=%0d required all 0",
                  bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.skip_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, "add_basic");
      run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "add_all_skip");
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
      run_op(16'h0010, 16'h0003, 1'b1, 1'b1, "sub_borrow_in");
      for (int i = 0; i < 4; i++)
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), "random");
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk);
      bus.a = 16'hABCD; bus.b = 16'h1357; bus.c_in = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.skip_cnt} !== '0) begin
         errors++;
         $display("FAIL abort_reset: got busy=%b done=%b sum=%h c_out=%b ovf=%b skip=%0d required all 0",
                  bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.skip_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done pulses required 0", seen);
      end
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t got;
      int   t1 = -1;
      int   t2 = -1;
      @(negedge clk);
      bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.c_in = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
      sb.push_back(model(16'h0F0F, 16'h00F1, 1'b1, 1'b0));
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         if (t == 2) begin
            bus.a = 16'h4000; bus.b = 16'h5000; bus.c_in = 1'b0; bus.sub = 1'b1;
            sb.push_back(model(16'h4000, 16'h5000, 1'b0, 1'b1));
         end
         if (bus.done) begin
            e   = sb.pop_front();
            got = {bus.sum, bus.c_out, bus.ovf, bus.skip_cnt};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL b2b_result: got sum=%h c_out=%b ovf=%b skip=%0d required sum=%h c_out=%b ovf=%b skip=%0d",
                        got.sum, got.c_out, got.ovf, got.skip, e.sum, e.c_out, e.ovf, e.skip);
            end
            if (t1 < 0) t1 = t;
            else begin
               t2 = t;
               bus.start = 1'b0;
               break;
            end
         end
      end
      bus.start = 1'b0;
      checks++;
      if (t1 < 0 || t2 < 0 || t2 - t1 !== NBLK + 2) begin
         errors++;
         $display("FAIL b2b_spacing: got done at %0d and %0d, required spacing %0d", t1, t2, NBLK + 2);
      end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_skip_adder.md
SERIAL_SKIP_ADDER -- requirements
Module: serial_skip_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter BLK, default 4: bits processed per cycle (one skip block).
REQ-003 SHALL fail elaboration if WIDTH is not a positive multiple of BLK; NBLK = WIDTH/BLK.
REQ-004 SHALL have port: clk  input  1  single clock, rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-007 SHALL have port: sub  input  1  0 = a+b+c_in; 1 = a-b-c_in.
REQ-008 SHALL have port: a, b  input  WIDTH  operands, captured on accepted start.
REQ-009 SHALL have port: c_in  input  1  carry-in (add) or borrow-in (sub).
REQ-010 SHALL have port: busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port: sum  output  WIDTH  result.
REQ-013 SHALL have port: c_out  output  1  final carry; for sub, 1 = no borrow.
REQ-014 SHALL have port: ovf  output  1  two's-complement signed overflow.
REQ-015 SHALL have port: skip_cnt  output  $clog2(NBLK+1)  number of blocks whose carry was skipped.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 In IDLE with start=1, SHALL capture a, b_eff = sub ? ~b : b, and carry = sub ? ~c_in : c_in; clear block index and skip_cnt; go to RUN.
REQ-018 In RUN, SHALL process block k (LSB first) each cycle: block sum = a_blk + b_eff_blk + carry; P = &(a_blk ^ b_eff_blk).
REQ-019 SHALL compute block carry-out as carry if P=1, else the ripple carry-out; skip_cnt SHALL increment when P=1.
REQ-020 SHALL write the block sum into sum[k*BLK +: BLK] at the end of the cycle.
REQ-021 After block NBLK-1, SHALL go to DONE; in DONE, SHALL raise done for exactly one cycle, then return to IDLE.
REQ-022 Latency SHALL be fixed: done is high at the (NBLK+1)th rising edge after the start edge (5 for defaults); throughput is one operation per NBLK+2 cycles.
REQ-023 SHALL set ovf = carry into the MSB XOR carry out of the MSB.
REQ-024 sum, c_out, ovf and skip_cnt SHALL hold their values from done until the next accepted start.
REQ-025 SHALL ignore start in RUN and DONE, with no queuing.
REQ-026 With start held high continuously, SHALL accept a new operation in the IDLE cycle after each DONE.
REQ-027 Operand changes after capture SHALL NOT affect the result in flight.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE and busy=0, done=0, sum=0, c_out=0, ovf=0, skip_cnt=0, independent of clk.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Structure
REQ-030 Package adder_pkg SHALL hold the FSM state enum and the ADD/SUB mode constants.
REQ-031 The combinational BLK-bit ripple block with propagate output SHALL be sub-module skip_block, instantiated once.
REQ-032 Block index and counters SHALL be sized from NBLK; no hard-coded widths.

Verification (WIDTH=16, BLK=4)
REQ-033 a=0x1234, b=0x1111, c_in=0, sub=0 -> sum=0x2345, c_out=0, ovf=0, skip_cnt=0, done at edge 5.
REQ-034 a=0xFFFF, b=0x0000, c_in=1, sub=0 -> sum=0x0000, c_out=1, ovf=0, skip_cnt=4.
REQ-035 a=0x0005, b=0x0007, c_in=0, sub=1 -> sum=0xFFFE, c_out=0, ovf=0, skip_cnt=3.
REQ-036 a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, c_out=0.
REQ-037 rst pulsed during the 2nd RUN cycle -> busy=0, all outputs 0, no done; the next start with 0x0001+0x0001 -> sum=0x0002.
REQ-038 start held high across two operations, with operands changed mid-RUN -> the first result uses the captured operands; the second done pulse arrives 6 cycles after the first.
